// File: rtl/vga_capture_if.sv
// vga_capture_if -- control handshake and VRAM write bus of the frame grabber.
//   start            one-cycle capture request (into the grabber)
//   busy, done       capture status (out of the grabber)
//   vram_write_*     single-beat VRAM write port (out of the grabber)
// master = the capture block, slave = the requester / VRAM side.
interface vga_capture_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] vram_write_addr;
  logic [15:0] vram_write_data;
  logic        vram_write_en;

  modport master (
    input  start,
    output busy, done, vram_write_addr, vram_write_data, vram_write_en
  );

  modport slave (
    output start,
    input  busy, done, vram_write_addr, vram_write_data, vram_write_en
  );
endinterface

// File: rtl/vga_capture.sv
// vga_capture -- grabs one VGA frame, decimated 4:1 in both axes (160x120),
// into VRAM as one 16-bit word per kept pixel.
// Ports:
//   clk, rst_n                 system clock (pixel rate clk/2), async active-low reset
//   vga_hs, vga_vs             active-low syncs, synchronous to clk
//   vga_r, vga_g, vga_b        4-bit colour
//   bus (vga_capture_if.master) start/busy/done and VRAM write port
//
// state | meaning
// IDLE  | waiting for start
// ARM   | start accepted, waiting for the frame-opening vsync fall
// CAPT  | writing kept pixels until the next vsync fall
// FIN   | one-cycle done pulse
module vga_capture #(
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned V_ACT_START = 31,
  parameter logic [15:0] BASE_ADDR   = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vga_hs,
  input  logic          vga_vs,
  input  logic [3:0]    vga_r,
  input  logic [3:0]    vga_g,
  input  logic [3:0]    vga_b,
  vga_capture_if.master bus
);

  localparam logic [10:0] H_LO = 11'(H_ACT_START);
  localparam logic [10:0] H_HI = 11'(H_ACT_START + 640);
  localparam logic [10:0] V_LO = 11'(V_ACT_START);
  localparam logic [10:0] V_HI = 11'(V_ACT_START + 480);

  typedef enum logic [1:0] {IDLE, ARM, CAPT, FIN} state_t;

  state_t      state;
  logic        pix_en;
  logic        hs_prev;
  logic        vs_prev;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [15:0] addr_cnt;

  logic        hs_fall;
  logic        vs_fall;
  logic [9:0]  hcnt_nxt;
  logic [9:0]  vcnt_nxt;
  logic        h_in;
  logic        v_in;
  logic [1:0]  x_ph;
  logic [1:0]  y_ph;
  logic        wr_req;

  // The pixel on a sample is tagged with the count value that sample
  // produces, so the hsync-fall pixel itself is column 0.
  always_comb begin
    hs_fall  = pix_en & hs_prev & ~vga_hs;
    vs_fall  = pix_en & vs_prev & ~vga_vs;
    hcnt_nxt = hcnt;
    vcnt_nxt = vcnt;
    if (pix_en) begin
      if (hs_fall)
        hcnt_nxt = 10'd0;
      else if (hcnt != 10'd1023)
        hcnt_nxt = hcnt + 10'd1;

      if (vs_fall)
        vcnt_nxt = 10'd0;
      else if (hs_fall && vcnt != 10'd1023)
        vcnt_nxt = vcnt + 10'd1;
    end
    h_in   = ({1'b0, hcnt_nxt} >= H_LO) && ({1'b0, hcnt_nxt} < H_HI);
    v_in   = ({1'b0, vcnt_nxt} >= V_LO) && ({1'b0, vcnt_nxt} < V_HI);
    x_ph   = hcnt_nxt[1:0] - H_LO[1:0];
    y_ph   = vcnt_nxt[1:0] - V_LO[1:0];
    wr_req = (state == CAPT) && pix_en && !vs_fall && h_in && v_in
             && (x_ph == 2'd0) && (y_ph == 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en  <= 1'b0;
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
      hcnt    <= 10'd0;
      vcnt    <= 10'd0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        hs_prev <= vga_hs;
        vs_prev <= vga_vs;
        hcnt    <= hcnt_nxt;
        vcnt    <= vcnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      addr_cnt            <= 16'h0000;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.vram_write_en   <= 1'b0;
      bus.vram_write_addr <= 16'h0000;
      bus.vram_write_data <= 16'h0000;
    end else begin
      bus.vram_write_en <= 1'b0;
      bus.done          <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= ARM;
            bus.busy <= 1'b1;
          end
        end
        ARM: begin
          if (vs_fall) begin
            state    <= CAPT;
            addr_cnt <= BASE_ADDR;
          end
        end
        CAPT: begin
          if (vs_fall) begin
            state    <= FIN;
            bus.done <= 1'b1;
          end else if (wr_req) begin
            bus.vram_write_en   <= 1'b1;
            bus.vram_write_addr <= addr_cnt;
            bus.vram_write_data <= {4'h0, vga_b, vga_g, vga_r};
            addr_cnt            <= addr_cnt + 16'h0001;
          end
        end
        FIN: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture -- self-checking bench for vga_capture.
// Two instances share one video source: dut0 at BASE_ADDR 0, dut1 at 16'hFF00.
// The video source generates frames from line/pixel indices; kept pixels carry
// the (x,y) pattern, every other pixel carries random colour. Expected VRAM
// contents follow directly from the 160x120 decimated frame layout.
module tb_vga_capture;
  localparam int H = 144;
  localparam int V = 31;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       vga_hs = 1'b1;
  logic       vga_vs = 1'b1;
  logic [3:0] vga_r  = 4'h0;
  logic [3:0] vga_g  = 4'h0;
  logic [3:0] vga_b  = 4'h0;
  logic       start  = 1'b0;

  int n_tests   = 0;
  int n_fail    = 0;
  int wr_cnt0   = 0;
  int wr_cnt1   = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  bit mon_on    = 1'b0;
  bit gen_go    = 1'b0;
  bit std_mode  = 1'b1;
  int frame_no  = -1;
  int line_no   = 0;

  always #5 clk = ~clk;

  vga_capture_if bus0();
  vga_capture_if bus1();
  assign bus0.start = start;
  assign bus1.start = start;

  vga_capture #(.H_ACT_START(H), .V_ACT_START(V), .BASE_ADDR(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .bus(bus0)
  );

  vga_capture #(.H_ACT_START(H), .V_ACT_START(V), .BASE_ADDR(16'hFF00)) dut1 (
    .clk(clk), .rst_n(rst_n), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .bus(bus1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word k of a frame is the pixel at x=4*(k%160), y=4*(k/160).
  function automatic logic [15:0] exp_word(input int k);
    int x, y;
    x = 4 * (k % 160);
    y = 4 * (k / 160);
    return {4'h0, 4'h5, 4'(y >> 2), 4'(x >> 2)};
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus0.vram_write_en) begin
        check_val("wr_addr0", 32'(bus0.vram_write_addr), 32'(16'(wr_cnt0)));
        check_val("wr_data0", 32'(bus0.vram_write_data), 32'(exp_word(wr_cnt0)));
        check_val("wr_busy0", 32'(bus0.busy), 32'd1);
        wr_cnt0++;
      end
      if (bus1.vram_write_en) begin
        check_val("wr_addr1", 32'(bus1.vram_write_addr), 32'(16'(32'hFF00 + wr_cnt1)));
        check_val("wr_data1", 32'(bus1.vram_write_data), 32'(exp_word(wr_cnt1)));
        wr_cnt1++;
      end
      if (bus0.done) begin
        check_val("en_with_done0", 32'(bus0.vram_write_en), 32'd0);
        done_cnt0++;
      end
      if (bus1.done) begin
        check_val("en_with_done1", 32'(bus1.vram_write_en), 32'd0);
        done_cnt1++;
      end
    end
  end

  // Video source. Standard mode: 800x525, hsync 96 px, vsync 2 lines.
  // Compressed mode: only lines holding kept pixels are full length, the
  // rest are 3..6 pixels with a single-pixel hsync.
  int g_nl, g_np, gx, gy;
  bit g_std;
  initial begin
    wait (gen_go);
    forever begin
      g_std = std_mode;
      g_nl  = g_std ? 525 : V + 480 + 2;
      frame_no++;
      for (int l = 0; l < g_nl; l++) begin
        line_no = l;
        gy = l - V;
        if (g_std || (gy >= 0 && gy < 480 && gy % 4 == 0))
          g_np = 800;
        else
          g_np = int'($urandom_range(6, 3));
        for (int p = 0; p < g_np; p++) begin
          @(negedge clk);
          gx = p - H;
          vga_hs = g_std ? (p >= 96) : (p != 0);
          vga_vs = (l >= 2);
          if (gx >= 0 && gx < 640 && gy >= 0 && gy < 480 && gx % 4 == 0 && gy % 4 == 0) begin
            vga_r = 4'(gx >> 2);
            vga_g = 4'(gy >> 2);
            vga_b = 4'h5;
          end else begin
            {vga_b, vga_g, vga_r} = 12'($urandom);
          end
          @(negedge clk);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // sel: 0 writes on dut0, 1 done pulses on dut0, 2 frame index, 3 line index
  task automatic wait_for(input string tag, input int sel, input int target, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk);
      case (sel)
        0:       hit = (wr_cnt0 >= target);
        1:       hit = (done_cnt0 >= target);
        2:       hit = (frame_no >= target);
        default: hit = (line_no >= target);
      endcase
    end
    check_val(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int f0, tgt;
    bit hit;

    repeat (4) @(negedge clk);
    check_val("rst_busy0", 32'(bus0.busy), 32'd0);
    check_val("rst_done0", 32'(bus0.done), 32'd0);
    check_val("rst_en0",   32'(bus0.vram_write_en), 32'd0);
    check_val("rst_addr0", 32'(bus0.vram_write_addr), 32'd0);
    check_val("rst_data0", 32'(bus0.vram_write_data), 32'd0);
    check_val("rst_addr1", 32'(bus1.vram_write_addr), 32'd0);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    repeat (3) @(negedge clk);
    check_val("idle_busy", 32'(bus0.busy), 32'd0);

    // Full standard frame, plus a start pulse while busy.
    pulse_start();
    check_val("busy_after_start", 32'(bus0.busy), 32'd1);
    gen_go = 1'b1;
    wait_for("wait_wr100", 0, 100, 400000);
    pulse_start();
    std_mode = 1'b0;
    wait_for("wait_done1", 1, 1, 2000000);
    repeat (4) @(negedge clk);
    check_val("f1_busy0",  32'(bus0.busy), 32'd0);
    check_val("f1_busy1",  32'(bus1.busy), 32'd0);
    check_val("f1_writes0", 32'(wr_cnt0), 32'd19200);
    check_val("f1_writes1", 32'(wr_cnt1), 32'd19200);
    check_val("f1_done0",  32'(done_cnt0), 32'd1);
    check_val("f1_done1",  32'(done_cnt1), 32'd1);
    repeat (1000) @(negedge clk);
    check_val("busy_start_ignored", 32'(bus0.busy), 32'd0);

    // Start in the middle of a frame.
    tgt = int'($urandom_range(400, 100));
    wait_for("wait_midline", 3, tgt, 400000);
    wr_cnt0 = 0;
    wr_cnt1 = 0;
    f0 = frame_no;
    pulse_start();
    check_val("mid_busy", 32'(bus0.busy), 32'd1);
    wait_for("wait_next_vs", 2, f0 + 1, 400000);
    check_val("no_wr_before_vs0", 32'(wr_cnt0), 32'd0);
    check_val("no_wr_before_vs1", 32'(wr_cnt1), 32'd0);
    wait_for("wait_done2", 1, 2, 600000);
    repeat (4) @(negedge clk);
    check_val("f2_writes0", 32'(wr_cnt0), 32'd19200);
    check_val("f2_writes1", 32'(wr_cnt1), 32'd19200);
    check_val("f2_done1",  32'(done_cnt1), 32'd2);
    check_val("f2_busy0",  32'(bus0.busy), 32'd0);

    // Reset on the write with index 5000.
    wr_cnt0 = 0;
    wr_cnt1 = 0;
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 600000 && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = bus0.vram_write_en && (wr_cnt0 == 5000);
    end
    check_val("reach_wr5000", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_en0",   32'(bus0.vram_write_en), 32'd0);
    check_val("rst_mid_en1",   32'(bus1.vram_write_en), 32'd0);
    check_val("rst_mid_busy0", 32'(bus0.busy), 32'd0);
    check_val("rst_mid_addr0", 32'(bus0.vram_write_addr), 32'd0);
    check_val("rst_mid_data1", 32'(bus1.vram_write_data), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    f0 = frame_no;
    wait_for("wait_two_frames", 2, f0 + 2, 600000);
    repeat (20) @(negedge clk);
    check_val("no_wr_after_rst0", 32'(wr_cnt0), 32'd5000);
    check_val("no_wr_after_rst1", 32'(wr_cnt1), 32'd5000);
    check_val("no_done_after_rst", 32'(done_cnt0), 32'd2);
    check_val("idle_after_rst", 32'(bus0.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
